// File: rtl/fpalu_pkg.sv
// fpalu_pkg: definitions shared by the FPALU, its scheduler and the requesters.
//   - FPALU opcode constants (OP_ADD..OP_SQRT)
//   - lat_of(op): cycles the FPALU needs before its result is valid
//   - flag bit positions of the 5-bit FPALU flag vector
//   - scheduler state encoding
package fpalu_pkg;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_MUL  = 4'h2;
  localparam logic [3:0] OP_DIV  = 4'h3;
  localparam logic [3:0] OP_SQRT = 4'h4;

  localparam int MAX_LAT = 16;

  localparam int FLAG_ZERO      = 0;
  localparam int FLAG_OVERFLOW  = 1;
  localparam int FLAG_UNDERFLOW = 2;
  localparam int FLAG_COMP      = 3;
  localparam int FLAG_NAN       = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_e;

  // Reserved/unknown opcodes finish in a single cycle.
  function automatic logic [4:0] lat_of(input logic [3:0] op);
    logic [4:0] lat;
    case (op)
      OP_ADD:  lat = 5'd7;
      OP_SUB:  lat = 5'd7;
      OP_MUL:  lat = 5'd5;
      OP_DIV:  lat = 5'd6;
      OP_SQRT: lat = 5'd16;
      default: lat = 5'd1;
    endcase
    return lat;
  endfunction

endpackage

// File: rtl/fpalu_sched_if.sv
// fpalu_sched_if: requester-side bundle of the FPALU scheduler.
//   ireq[1:0]            request levels, held until the matching odone bit
//   icontrolN/idataaN/idatabN  opcode and operands of requester N
//   odone[1:0]           one-cycle completion pulse to the served requester
//   oresult/oflags       last captured result and flags (shared)
//   obusy                scheduler not idle
// master = requesters, slave = scheduler.
interface fpalu_sched_if;
  logic [1:0]  ireq;
  logic [3:0]  icontrol0;
  logic [3:0]  icontrol1;
  logic [31:0] idataa0;
  logic [31:0] idataa1;
  logic [31:0] idatab0;
  logic [31:0] idatab1;
  logic [1:0]  odone;
  logic [31:0] oresult;
  logic [4:0]  oflags;
  logic        obusy;

  modport master (
    output ireq, icontrol0, icontrol1, idataa0, idataa1, idatab0, idatab1,
    input  odone, oresult, oflags, obusy
  );

  modport slave (
    input  ireq, icontrol0, icontrol1, idataa0, idataa1, idatab0, idatab1,
    output odone, oresult, oflags, obusy
  );
endinterface

// File: rtl/fpalu_rr_arb2.sv
// fpalu_rr_arb2: combinational two-way round-robin pick.
//   req[1:0]    request levels
//   last_grant  index granted last time
//   gnt_idx     chosen requester
//   gnt_valid   at least one request present
module fpalu_rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       gnt_idx,
  output logic       gnt_valid
);

  // Lone requester wins outright; on a tie the one not served last wins.
  always_comb begin
    gnt_valid = |req;
    case (req)
      2'b01:   gnt_idx = 1'b0;
      2'b10:   gnt_idx = 1'b1;
      2'b11:   gnt_idx = ~last_grant;
      default: gnt_idx = 1'b0;
    endcase
  end

endmodule

// File: rtl/fpalu_sched.sv
// fpalu_sched: shares one FPALU between two requesters.
//   iclock, ireset_n     clock, asynchronous active-low reset
//   bus (slave)          requester bundle (ireq/icontrol/idata in, odone/oresult/oflags/obusy out)
//   ofpu_control/dataa/datab  operands held stable on the FPALU for the whole operation
//   ifpu_result/flags    FPALU outputs, captured once the opcode latency has elapsed
// Every output is a flop; requester inputs are only looked at while IDLE.
module fpalu_sched #(
  parameter int LAT_W = 5
) (
  input  logic          iclock,
  input  logic          ireset_n,
  fpalu_sched_if.slave  bus,
  output logic [3:0]    ofpu_control,
  output logic [31:0]   ofpu_dataa,
  output logic [31:0]   ofpu_datab,
  input  logic [31:0]   ifpu_result,
  input  logic [4:0]    ifpu_flags
);
  import fpalu_pkg::*;

  state_e             state_q, state_d;
  logic [LAT_W-1:0]   cnt_q, cnt_d;
  logic               winner_q, winner_d;
  logic               last_grant_q, last_grant_d;
  logic [3:0]         ctl_q, ctl_d;
  logic [31:0]        dataa_q, dataa_d;
  logic [31:0]        datab_q, datab_d;
  logic [31:0]        result_q, result_d;
  logic [4:0]         flags_q, flags_d;
  logic [1:0]         odone_q, odone_d;
  logic               obusy_q, obusy_d;

  logic               gnt_idx_s;
  logic               gnt_valid_s;
  logic [3:0]         sel_ctl_s;

  fpalu_rr_arb2 u_arb (
    .req        (bus.ireq),
    .last_grant (last_grant_q),
    .gnt_idx    (gnt_idx_s),
    .gnt_valid  (gnt_valid_s)
  );

  assign sel_ctl_s = gnt_idx_s ? bus.icontrol1 : bus.icontrol0;

  // Next-state, latency counter and capture logic.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    winner_d     = winner_q;
    last_grant_d = last_grant_q;
    ctl_d        = ctl_q;
    dataa_d      = dataa_q;
    datab_d      = datab_q;
    result_d     = result_q;
    flags_d      = flags_q;
    odone_d      = 2'b00;
    case (state_q)
      IDLE: begin
        if (gnt_valid_s) begin
          state_d      = EXEC;
          winner_d     = gnt_idx_s;
          last_grant_d = gnt_idx_s;
          ctl_d        = sel_ctl_s;
          dataa_d      = gnt_idx_s ? bus.idataa1 : bus.idataa0;
          datab_d      = gnt_idx_s ? bus.idatab1 : bus.idatab0;
          // Counter expires L cycles after this edge, so it starts at L-1.
          cnt_d        = LAT_W'(lat_of(sel_ctl_s) - 5'd1);
        end else begin
          state_d = IDLE;
        end
      end
      EXEC: begin
        if (cnt_q == '0) begin
          state_d  = DONE;
          result_d = ifpu_result;
          flags_d  = ifpu_flags;
          odone_d  = winner_q ? 2'b10 : 2'b01;
        end else begin
          cnt_d = cnt_q - LAT_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    obusy_d = (state_d != IDLE);
  end

  // State and output registers.
  always_ff @(posedge iclock or negedge ireset_n) begin
    if (!ireset_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      winner_q     <= 1'b0;
      last_grant_q <= 1'b1;
      ctl_q        <= 4'h0;
      dataa_q      <= 32'h0;
      datab_q      <= 32'h0;
      result_q     <= 32'h0;
      flags_q      <= 5'h0;
      odone_q      <= 2'b00;
      obusy_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      winner_q     <= winner_d;
      last_grant_q <= last_grant_d;
      ctl_q        <= ctl_d;
      dataa_q      <= dataa_d;
      datab_q      <= datab_d;
      result_q     <= result_d;
      flags_q      <= flags_d;
      odone_q      <= odone_d;
      obusy_q      <= obusy_d;
    end
  end

  assign ofpu_control = ctl_q;
  assign ofpu_dataa   = dataa_q;
  assign ofpu_datab   = datab_q;
  assign bus.odone    = odone_q;
  assign bus.oresult  = result_q;
  assign bus.oflags   = flags_q;
  assign bus.obusy    = obusy_q;

endmodule

// File: doc/fpalu_sched.md
# fpalu_sched

Two-requester scheduler for the shared single-precision FPALU. It arbitrates round-robin between requesters 0 and 1 and holds the winner's operands and opcode stable on the FPALU inputs. It waits the opcode-specific latency, then captures result and flags and returns them with a one-cycle done pulse. It sits between the FPALU instance and its clients (core FP pipeline and board test harness).

## Interface
- LAT_W, 5: latency down-counter width; must hold max latency − 1.
- iclock  in  1  system clock.
- ireset_n  in  1  asynchronous, active-low reset.
- ireq  in  2  per-requester request level; held until that requester's odone.
- icontrol0, icontrol1  in  4  opcode, FPALU encoding.
- idataa0, idataa1  in  32  operand A.
- idatab0, idatab1  in  32  operand B.
- odone  out  2  one-cycle pulse to the served requester.
- oresult  out  32  captured result; shared by both requesters; holds until next capture.
- oflags  out  5  captured flags: [0] zero, [1] overflow, [2] underflow, [3] CompResult, [4] NaN.
- obusy  out  1  high whenever state ≠ IDLE.
- ofpu_control  out  4  to FPALU icontrol.
- ofpu_dataa, ofpu_datab  out  32  to FPALU operands.
- ifpu_result  in  32  from FPALU oresult.
- ifpu_flags  in  5  from FPALU; same bit order as oflags.

## Operation
- States:
  - IDLE: sample ireq.
  - EXEC: count down the latency.
  - DONE: pulse odone.
  - After DONE, return to IDLE unconditionally.
- IDLE → EXEC, when any ireq bit is high:
  - Pick winner.
  - Latch winner's opcode and operands into the ofpu_* registers.
  - Load counter = LAT(op) − 1.
  - Record winner index and last_grant.
- Arbitration:
  - Single requester wins outright.
  - If both request, grant the one ≠ last_grant.
  - last_grant resets to 1, so requester 0 wins the first tie.
- EXEC:
  - Counter decrements each cycle.
  - At the edge where counter == 0: capture ifpu_result → oresult and ifpu_flags → oflags, then go to DONE.
- DONE: odone[winner] = 1 for exactly this cycle. All other cycles odone = 2'b00.
- LAT(op), fixed in package:
  - ADD 4'h0 = 7
  - SUB 4'h1 = 7
  - MUL 4'h2 = 5
  - DIV 4'h3 = 6
  - SQRT 4'h4 = 16
  - all other opcodes = 1 (including reserved ones).
- Operand isolation:
  - ofpu_* change only on the IDLE → EXEC edge.
  - Requester input changes during EXEC/DONE have no effect.
- ireq is ignored outside IDLE. A requester deasserts ireq at the edge where it sees odone; if it is still high when IDLE is next sampled, that is a new request.
- Reset (any time, including mid-EXEC):
  - State → IDLE; counter → 0; last_grant → 1.
  - All outputs → 0: oresult, oflags, ofpu_*, odone, obusy.
  - The in-flight op is discarded and no odone is issued.

## Timing
- Edge E0: IDLE samples ireq; ofpu_* valid from E0.
- Edge E_L (L = LAT(op)): result captured. Operands are stable on the FPALU for exactly L cycles before capture.
- odone high from E_L to E_L+1.
- IDLE re-entered at E_L+1; next sample at E_L+2.
- Throughput: one op per L+2 cycles.
- L = 1: capture at E1, odone during E1→E2.
- obusy rises at E0 and falls at E_L+1.
- No combinational path from any input to any output; all outputs are registered.

## Structure
- Shared package fpalu_pkg holds:
  - opcode constants (OP_ADD…OP_SQRT);
  - latency function lat_of(op) and max-latency constant;
  - flag bit indices;
  - state enum {IDLE, EXEC, DONE}.
- The FPALU and requester top levels import the same package.
- One sub-module, fpalu_rr_arb2: combinational 2-way round-robin pick from ireq and last_grant, returning the grant index and valid. The FSM, counter and capture registers stay in fpalu_sched.

## Test plan
- Add: req0 issues ADD, a = 32'h3F800000, b = 32'h40000000; FPALU model returns 32'h40400000 after 7 cycles → odone = 2'b01 exactly at E7 for one cycle, oresult = 32'h40400000, oflags = 5'b00000, obusy high E0..E8.
- Tie: both ireq held continuously from reset with distinct opcodes → service order 0, 1, 0, 1; odone never two bits at once.
- Latency sweep: each of ADD/SUB/MUL/DIV/SQRT plus opcode 4'h9 → capture at E7/E7/E5/E6/E16/E1 respectively.
- Isolation: during req0 MUL, toggle idataa1/idatab1/icontrol1 every cycle → ofpu_* constant E0..E5; req1 served afterwards with its final values.
- Flags: model drives ifpu_flags = 5'b00010 on MUL → oflags = 5'b00010 captured and held through a following ireq-free interval.
- Reset: assert ireset_n = 0 at E8 of SQRT → outputs all 0 immediately, no odone. After release, a new ADD completes normally at E7.
